// File: rtl/lane_reorder_v2.sv
// Receive lane reorder: learns the physical-to-logical lane map from lane IDs, confirms it,
// and serialises each N_LANES-wide word into logical-order beats of OUT_LANES blocks.
//
//   state      | meaning
//   ST_IDLE    | no deskew; identity map restored at next word load
//   ST_COLLECT | gathering N_CONFIRM identical valid ID samples
//   ST_LOCKED  | confirmed map active; counting consecutive misses
module lane_reorder_v2 #(
    parameter int NB_DATA   = 66,
    parameter int N_LANES   = 20,
    parameter int OUT_LANES = 1,
    parameter int NB_ID     = $clog2(N_LANES),
    parameter int N_CONFIRM = 3,
    parameter int NB_ERR    = 8
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_enable,
    input  logic                         i_rf_reset_order,
    input  logic                         i_deskew_done,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [N_LANES*NB_DATA-1:0]   i_data,
    input  logic [N_LANES-1:0]           i_tag,
    input  logic [N_LANES*NB_ID-1:0]     i_logical_rx_ID,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [OUT_LANES*NB_DATA-1:0] o_data,
    output logic [OUT_LANES-1:0]         o_tag,
    output logic                         o_locked,
    output logic                         o_id_error,
    output logic [NB_ERR-1:0]            o_err_count
);

    localparam int N_BEATS = N_LANES / OUT_LANES;
    localparam int NB_BEAT = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int NB_CNT  = $clog2(N_CONFIRM + 1);
    localparam int NB_MAP  = N_LANES * NB_ID;

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_LOCKED} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_deskew_q;
    logic [NB_MAP-1:0]    r_cand;
    logic [NB_MAP-1:0]    r_map;
    logic [NB_CNT-1:0]    r_cnt;
    logic [NB_CNT-1:0]    r_miss;
    logic                 r_pend;
    logic                 r_ident;
    logic [NB_ID-1:0]     r_sel [N_LANES];
    logic [NB_ID-1:0]     w_sel_next [N_LANES];
    logic [NB_DATA-1:0]   r_buf_data [N_LANES];
    logic [N_LANES-1:0]   r_buf_tag;
    logic                 r_buf_valid;
    logic [NB_BEAT-1:0]   r_beat;
    logic                 r_id_error;
    logic [NB_ERR-1:0]    r_err_cnt;
    logic [NB_ID-1:0]     w_slot_sel [OUT_LANES];

    logic [N_LANES-1:0]   w_seen;
    logic                 w_id_ok;
    logic                 w_accept;
    logic                 w_sample;
    logic                 w_bad_sample;
    logic                 w_last;
    logic                 w_fire;
    logic                 w_rise;
    logic                 w_cand_eq;
    logic                 w_map_eq;
    logic                 w_hit;
    logic                 w_clear;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;
    logic                 w_cand_load;
    logic                 w_commit;
    logic                 w_miss_inc;
    logic                 w_miss_clr;

    assign w_last       = (r_beat == NB_BEAT'(N_BEATS - 1));
    assign o_valid      = i_enable && r_buf_valid;
    assign o_ready      = i_enable && (!r_buf_valid || (w_last && i_ready));
    assign w_fire       = o_valid && i_ready;
    assign w_accept     = i_valid && o_ready;
    assign w_sample     = w_accept && i_deskew_done;
    assign w_bad_sample = w_sample && !w_id_ok;
    assign w_rise       = i_deskew_done && !r_deskew_q;
    assign w_cand_eq    = (r_cnt != '0) && (i_logical_rx_ID == r_cand);
    assign w_map_eq     = (i_logical_rx_ID == r_map);
    assign w_hit        = w_cand_eq ? ((r_cnt + NB_CNT'(1)) == NB_CNT'(N_CONFIRM))
                                    : (N_CONFIRM == 1);

    assign o_locked     = (r_state == ST_LOCKED);
    assign o_id_error   = r_id_error;
    assign o_err_count  = r_err_cnt;

    // N IDs covering all N values implies every ID is in range and none repeats.
    always_comb begin
        w_seen = '0;
        for (int l = 0; l < N_LANES; l++) begin
            for (int p = 0; p < N_LANES; p++) begin
                if (i_logical_rx_ID[p*NB_ID +: NB_ID] == NB_ID'(l)) w_seen[l] = 1'b1;
            end
        end
    end
    assign w_id_ok = &w_seen;

    always_comb begin
        for (int l = 0; l < N_LANES; l++) w_sel_next[l] = r_sel[l];
        if (r_ident) begin
            for (int l = 0; l < N_LANES; l++) w_sel_next[l] = NB_ID'(l);
        end else if (r_pend) begin
            for (int l = 0; l < N_LANES; l++) begin
                for (int p = 0; p < N_LANES; p++) begin
                    if (r_map[p*NB_ID +: NB_ID] == NB_ID'(l)) w_sel_next[l] = NB_ID'(p);
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cand_load  = 1'b0;
        w_commit     = 1'b0;
        w_miss_inc   = 1'b0;
        w_miss_clr   = 1'b0;
        if (i_rf_reset_order) begin
            w_clear      = 1'b1;
            w_state_next = i_deskew_done ? ST_COLLECT : ST_IDLE;
        end else if (!i_deskew_done) begin
            w_clear      = 1'b1;
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_next = ST_COLLECT;
                        w_cnt_clr    = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_sample) begin
                        if (!w_id_ok) begin
                            w_cnt_clr = 1'b1;
                        end else if (w_hit) begin
                            w_commit     = 1'b1;
                            w_state_next = ST_LOCKED;
                        end else if (w_cand_eq) begin
                            w_cnt_inc = 1'b1;
                        end else begin
                            w_cand_load = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_sample) begin
                        if (w_id_ok && w_map_eq) begin
                            w_miss_clr = 1'b1;
                        end else if ((r_miss + NB_CNT'(1)) == NB_CNT'(N_CONFIRM)) begin
                            w_state_next = ST_COLLECT;
                            w_cnt_clr    = 1'b1;
                            w_miss_clr   = 1'b1;
                        end else begin
                            w_miss_inc = 1'b1;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_deskew_q  <= 1'b0;
            r_cand      <= '0;
            r_map       <= '0;
            r_cnt       <= '0;
            r_miss      <= '0;
            r_pend      <= 1'b0;
            r_ident     <= 1'b0;
            r_buf_valid <= 1'b0;
            r_beat      <= '0;
            r_id_error  <= 1'b0;
            r_err_cnt   <= '0;
            for (int l = 0; l < N_LANES; l++) r_sel[l] <= NB_ID'(l);
        end else if (i_enable) begin
            r_state    <= w_state_next;
            r_deskew_q <= i_deskew_done;
            r_id_error <= w_bad_sample;
            if (w_bad_sample && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + NB_ERR'(1);

            // Map changes take effect only on a fresh word so no word mixes two mappings.
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_beat      <= '0;
                r_pend      <= 1'b0;
                r_ident     <= 1'b0;
                for (int l = 0; l < N_LANES; l++) r_sel[l] <= w_sel_next[l];
            end else if (w_fire) begin
                if (w_last) begin
                    r_buf_valid <= 1'b0;
                    r_beat      <= '0;
                end else begin
                    r_beat <= r_beat + NB_BEAT'(1);
                end
            end

            // Placed after the load so a same-cycle request survives into the next load.
            if (w_clear) begin
                r_cnt   <= '0;
                r_miss  <= '0;
                r_pend  <= 1'b0;
                r_ident <= 1'b1;
            end else begin
                if (w_cnt_clr)   r_cnt <= '0;
                if (w_cnt_inc)   r_cnt <= r_cnt + NB_CNT'(1);
                if (w_cand_load) begin
                    r_cand <= i_logical_rx_ID;
                    r_cnt  <= NB_CNT'(1);
                end
                if (w_commit) begin
                    r_map   <= i_logical_rx_ID;
                    r_pend  <= 1'b1;
                    r_ident <= 1'b0;
                    r_cnt   <= '0;
                    r_miss  <= '0;
                end
                if (w_miss_clr) r_miss <= '0;
                if (w_miss_inc) r_miss <= r_miss + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            for (int p = 0; p < N_LANES; p++) r_buf_data[p] <= i_data[p*NB_DATA +: NB_DATA];
            r_buf_tag <= i_tag;
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_LANES; k++) begin
            w_slot_sel[k] = '0;
            for (int b = 0; b < N_BEATS; b++) begin
                if (r_beat == NB_BEAT'(b)) w_slot_sel[k] = r_sel[b*OUT_LANES + k];
            end
        end
    end

    always_comb begin
        o_data = '0;
        o_tag  = '0;
        for (int k = 0; k < OUT_LANES; k++) begin
            for (int p = 0; p < N_LANES; p++) begin
                if (w_slot_sel[k] == NB_ID'(p)) begin
                    o_data[k*NB_DATA +: NB_DATA] = r_buf_data[p];
                    o_tag[k]                     = r_buf_tag[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_reorder_v2.sv
// Scoreboard bench for lane_reorder_v2 with 4 lanes, 2 blocks per beat, 3-sample confirm.
module tb_lane_reorder_v2;

    localparam logic [7:0] ID_A   = 8'h72;   // lane IDs {2,0,3,1}
    localparam logic [7:0] SEL_A  = 8'h8D;   // logical -> physical {1,3,0,2}
    localparam logic [7:0] ID_B   = 8'hB1;   // lane IDs {1,0,3,2}, self-inverse
    localparam logic [7:0] SEL_B  = 8'hB1;
    localparam logic [7:0] ID_DUP = 8'hE0;   // lane IDs {0,0,2,3}
    localparam logic [7:0] SEL_I  = 8'hE4;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic        i_enable;
    logic        i_rf_reset_order;
    logic        i_deskew_done;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [3:0]  i_tag;
    logic [7:0]  i_logical_rx_ID;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_data;
    logic [1:0]  o_tag;
    logic        o_locked;
    logic        o_id_error;
    logic [7:0]  o_err_count;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          wb     = 0;
    logic [17:0] exp_q[$];

    lane_reorder_v2 #(
        .NB_DATA(8), .N_LANES(4), .OUT_LANES(2), .NB_ID(2), .N_CONFIRM(3), .NB_ERR(8)
    ) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
        .i_rf_reset_order(i_rf_reset_order), .i_deskew_done(i_deskew_done),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_tag(i_tag),
        .i_logical_rx_ID(i_logical_rx_ID), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_tag(o_tag), .o_locked(o_locked), .o_id_error(o_id_error),
        .o_err_count(o_err_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [17:0] exp_beat(input logic [7:0] base, input logic [3:0] tags,
                                             input logic [7:0] sel, input int b);
        logic [17:0] e;
        logic [7:0]  sv;
        int          p;
        e  = '0;
        sv = sel;
        for (int k = 0; k < 2; k++) begin
            p = int'(sv[(b*2 + k)*2 +: 2]);
            e[k*8 +: 8] = 8'(int'(base) + p);
            e[16 + k]   = tags[p];
        end
        return e;
    endfunction

    always @(negedge i_clock) begin
        if (i_reset_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", {14'd0, o_tag, o_data}, 32'h0);
            else chk("beat", {14'd0, o_tag, o_data}, {14'd0, exp_q.pop_front()});
        end
    end

    task automatic send_word(input logic [7:0] ids, input logic [7:0] base,
                             input logic [3:0] tags, input logic [7:0] sel);
        bit ok;
        for (int p = 0; p < 4; p++) i_data[p*8 +: 8] = 8'(int'(base) + p);
        i_tag           = tags;
        i_logical_rx_ID = ids;
        i_valid         = 1'b1;
        ok              = 1'b0;
        for (int g = 0; g < 50 && !ok; g++) begin
            @(negedge i_clock);
            if (o_ready) begin
                exp_q.push_back(exp_beat(base, tags, sel, 0));
                exp_q.push_back(exp_beat(base, tags, sel, 1));
                ok = 1'b1;
            end
            @(posedge i_clock);
        end
        #1;
        i_valid = 1'b0;
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic send(input logic [7:0] ids, input logic [7:0] sel);
        send_word(ids, 8'(wb), 4'(wb >> 4), sel);
        wb = (wb + 16) % 256;
    endtask

    task automatic drain();
        for (int g = 0; g < 100 && exp_q.size() != 0; g++) @(posedge i_clock);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] hold_exp;
        i_reset_n = 1'b0; i_enable = 1'b1; i_rf_reset_order = 1'b0; i_deskew_done = 1'b0;
        i_valid = 1'b0; i_data = '0; i_tag = '0; i_logical_rx_ID = '0; i_ready = 1'b1;
        repeat (3) @(posedge i_clock);
        #1 i_reset_n = 1'b1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_locked", o_locked, 0);
        chk("rst_id_error", o_id_error, 0);
        chk("rst_err_count", o_err_count, 0);
        i_enable = 1'b0;
        #1 chk("disabled_ready", o_ready, 0);
        i_enable = 1'b1;

        // Before deskew the identity map applies whatever IDs arrive.
        send(ID_A, SEL_I);
        drain();

        // Learn map A: three confirming words, lock, then the 4th word is reordered.
        @(posedge i_clock); #1 i_deskew_done = 1'b1;
        repeat (2) @(posedge i_clock); #1;
        send(ID_A, SEL_I);
        send(ID_A, SEL_I);
        chk("lock_after2", o_locked, 0);
        send(ID_A, SEL_I);
        chk("lock_after3", o_locked, 1);
        send_word(ID_A, 8'hA0, 4'b0110, SEL_A);
        chk("plan_beat0", exp_beat(8'hA0, 4'b0110, SEL_A, 0), 18'h1A3A1);
        drain();

        // Two stray samples then a match: stays locked.
        send(ID_B, SEL_A);
        send(ID_B, SEL_A);
        send(ID_A, SEL_A);
        chk("flaky_locked", o_locked, 1);
        for (int i = 0; i < 3; i++) send(ID_B, SEL_A);
        chk("unlock", o_locked, 0);
        send(ID_B, SEL_A);
        send(ID_B, SEL_A);
        chk("relock_early", o_locked, 0);
        send(ID_B, SEL_A);
        chk("relock", o_locked, 1);
        send(ID_B, SEL_B);
        drain();

        // Backpressure mid-word, then back-to-back follow-up word.
        send_word(ID_B, 8'h30, 4'b1001, SEL_B);
        hold_exp = exp_beat(8'h30, 4'b1001, SEL_B, 1);
        @(posedge i_clock); #1 i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clock);
            chk("hold_data", {14'd0, o_tag, o_data}, {14'd0, hold_exp});
            chk("hold_ready", o_ready, 0);
            chk("hold_valid", o_valid, 1);
        end
        @(posedge i_clock); #1 i_ready = 1'b1;
        send_word(ID_B, 8'h50, 4'b0011, SEL_B);
        @(negedge i_clock);
        chk("no_bubble", o_valid, 1);
        drain();

        // Register-file order reset while locked.
        chk("pre_rf_locked", o_locked, 1);
        @(posedge i_clock); #1 i_rf_reset_order = 1'b1;
        @(posedge i_clock); #1 i_rf_reset_order = 1'b0;
        chk("rf_unlock", o_locked, 0);
        send(ID_A, SEL_I);
        send(ID_A, SEL_I);

        // A bad sample clears confirmation progress.
        send(ID_DUP, SEL_I);
        chk("dup_pulse", o_id_error, 1);
        chk("dup_count", o_err_count, 1);
        @(posedge i_clock); #1;
        chk("dup_pulse_end", o_id_error, 0);
        send(ID_A, SEL_I);
        send(ID_A, SEL_I);
        chk("restart_nolock", o_locked, 0);
        send(ID_A, SEL_I);
        chk("restart_lock", o_locked, 1);

        // Saturating error counter.
        for (int i = 1; i <= 300; i++) begin
            send(ID_DUP, SEL_A);
            if (i == 200) chk("err_count_200", o_err_count, 201);
        end
        chk("err_count_sat", o_err_count, 255);
        drain();

        // Async reset in the middle of a word.
        send(ID_A, SEL_A);
        #2 i_reset_n = 1'b0;
        #1 chk("reset_valid", o_valid, 0);
        chk("reset_err_count", o_err_count, 0);
        exp_q.delete();
        repeat (2) @(posedge i_clock);
        #1 i_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clock);
            chk("post_reset_idle", o_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
